// File: rtl/ctx_regfile_if.sv
// rtl/ctx_regfile_if.sv - read, write and clear bus of the multi-context register file
interface ctx_regfile_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NCTX   = 2
);
  localparam int RW = $clog2(NREG);
  localparam int CW = (NCTX > 1) ? $clog2(NCTX) : 1;
  localparam int AW = CW + RW;

  logic [AW-1:0]     rd0_addr;
  logic [AW-1:0]     rd1_addr;
  logic [DATA_W-1:0] rd0_data;
  logic [DATA_W-1:0] rd1_data;
  logic              lnk_we;
  logic              sav_we;
  logic [CW-1:0]     e_ctx;
  logic [DATA_W-1:0] e_data;
  logic              m_we;
  logic [AW-1:0]     m_addr;
  logic [DATA_W-1:0] m_data;
  logic              w_we;
  logic [AW-1:0]     w_addr;
  logic [DATA_W-1:0] w_data;
  logic              clr_req;
  logic [CW-1:0]     clr_ctx;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output rd0_addr, rd1_addr, lnk_we, sav_we, e_ctx, e_data,
           m_we, m_addr, m_data, w_we, w_addr, w_data, clr_req, clr_ctx,
    input  rd0_data, rd1_data, clr_busy, clr_done
  );

  modport slave (
    input  rd0_addr, rd1_addr, lnk_we, sav_we, e_ctx, e_data,
           m_we, m_addr, m_data, w_we, w_addr, w_data, clr_req, clr_ctx,
    output rd0_data, rd1_data, clr_busy, clr_done
  );
endinterface

// File: rtl/ctx_regfile.sv
// rtl/ctx_regfile.sv - multi-context register file, prioritised writes, bypass reads, context clear
module ctx_regfile #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int NCTX     = 2,
  parameter int LINK_REG = 31,
  parameter int SAVE_REG = 1
) (
  input logic          clk,
  input logic          rst,
  ctx_regfile_if.slave bus
);
  localparam int RW   = $clog2(NREG);
  localparam int CW   = (NCTX > 1) ? $clog2(NCTX) : 1;
  localparam int AW   = CW + RW;
  localparam int NENT = NCTX * NREG;
  localparam logic [RW-1:0] LAST_IDX = RW'(NREG - 1);
  localparam logic [RW-1:0] LINK_IDX = RW'(LINK_REG);
  localparam logic [RW-1:0] SAVE_IDX = RW'(SAVE_REG);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cctx_q, cctx_d;
  logic              busy;
  logic              done_c;
  logic [DATA_W-1:0] mem [NENT];

  // A single-context file ignores the context field of every address.
  function automatic logic [AW-1:0] norm(input logic [AW-1:0] a);
    if (NCTX == 1) return {{CW{1'b0}}, a[RW-1:0]};
    return a;
  endfunction

  function automatic logic blocked(input logic [AW-1:0] a, input logic b,
                                   input logic [CW-1:0] c);
    return (a[RW-1:0] == '0) || (b && (a[AW-1:RW] == c));
  endfunction

  logic [AW-1:0] lnk_a, sav_a, m_a, w_a;
  logic          lnk_ok, sav_ok, m_ok, w_ok;

  assign busy   = (state_q != IDLE);
  assign lnk_a  = norm({bus.e_ctx, LINK_IDX});
  assign sav_a  = norm({bus.e_ctx, SAVE_IDX});
  assign m_a    = norm(bus.m_addr);
  assign w_a    = norm(bus.w_addr);
  assign lnk_ok = bus.lnk_we && !blocked(lnk_a, busy, cctx_q);
  assign sav_ok = bus.sav_we && !blocked(sav_a, busy, cctx_q);
  assign m_ok   = bus.m_we && !blocked(m_a, busy, cctx_q);
  assign w_ok   = bus.w_we && !blocked(w_a, busy, cctx_q);

  logic [1:0][AW-1:0]     ra;
  logic [1:0][DATA_W-1:0] rv;

  assign ra[0] = norm(bus.rd0_addr);
  assign ra[1] = norm(bus.rd1_addr);

  // Later assignments override earlier ones, so the order below is lowest to highest priority.
  always_comb begin
    rv = '0;
    for (int p = 0; p < 2; p++) begin
      rv[p] = mem[ra[p]];
      if (w_ok && (w_a == ra[p]))     rv[p] = bus.w_data;
      if (m_ok && (m_a == ra[p]))     rv[p] = bus.m_data;
      if (sav_ok && (sav_a == ra[p])) rv[p] = bus.e_data;
      if (lnk_ok && (lnk_a == ra[p])) rv[p] = bus.e_data;
      if (blocked(ra[p], busy, cctx_q)) rv[p] = '0;
    end
  end

  assign bus.rd0_data = rv[0];
  assign bus.rd1_data = rv[1];
  assign bus.clr_busy = busy;
  assign bus.clr_done = done_c;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cctx_d  = cctx_q;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          cctx_d  = (NCTX == 1) ? '0 : bus.clr_ctx;
          ptr_d   = RW'(1);
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + RW'(1);
        if (ptr_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cctx_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cctx_q  <= cctx_d;
    end
  end

  // Writes to the clearing context are already masked, so the clear never collides with them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NENT; i++) mem[i] <= '0;
    end else begin
      if (state_q == CLEAR) mem[{cctx_q, ptr_q}] <= '0;
      if (w_ok)   mem[w_a]   <= bus.w_data;
      if (m_ok)   mem[m_a]   <= bus.m_data;
      if (sav_ok) mem[sav_a] <= bus.e_data;
      if (lnk_ok) mem[lnk_a] <= bus.e_data;
    end
  end
endmodule
